// File: rtl/tape_player_if.sv
// Byte-stream write channel from the image downloader into the tape player FIFO.
interface tape_player_if;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_last;

  modport master (output wr_data, output wr_valid, output wr_last, input wr_ready);
  modport slave  (input wr_data, input wr_valid, input wr_last, output wr_ready);
endinterface

// File: rtl/tape_player.sv
// TAP cassette image playback: byte FIFO, header/v0/v1 pulse parser and
// cassette read waveform regeneration on a clock-enable timebase.
module tape_player #(
  parameter int FIFO_AW    = 10,
  parameter int HDR_LEN    = 20,
  parameter int VER_OFS    = 12,
  parameter int UNIT_SHIFT = 3,
  parameter int CNT_W      = 24,
  parameter int V1_EN      = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce_tick,
  input  logic               restart,
  tape_player_if.slave       wr,
  input  logic               play,
  input  logic               motor_n,
  output logic               tape_out,
  output logic               playing,
  output logic               done,
  output logic [7:0]         version,
  output logic [FIFO_AW:0]   fifo_level
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int HI_W  = $clog2(HDR_LEN + 1);

  typedef enum logic [2:0] {S_HDR, S_FETCH, S_EXT0, S_EXT1, S_EXT2, S_PULSE} state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level_nxt;
  logic               wr_ready_q;
  logic               empty;
  logic               push, pop, pop_hdr, pop_dat;

  logic [7:0]         rd_data_p1;
  logic               vld_p1;
  logic               ver_vld_p1;

  state_t             state, state_nxt;
  logic [HI_W-1:0]    hdr_idx;
  logic               last_seen;
  logic               done_set;
  logic               gate;
  logic               tape_nxt;
  logic [CNT_W-1:0]   len, len_nxt, count, count_nxt;
  logic [15:0]        ext_acc, ext_nxt;

  function automatic logic [CNT_W-1:0] tap_len(input logic [8:0] units);
    return CNT_W'(units) << UNIT_SHIFT;
  endfunction

  function automatic logic [CNT_W-1:0] ext_len(input logic [23:0] raw);
    return CNT_W'(raw);
  endfunction

  assign empty      = (fifo_level == '0);
  assign push       = wr.wr_valid && wr_ready_q && !restart;
  assign pop_hdr    = (state == S_HDR) && !empty && !restart;
  assign pop_dat    = (state inside {S_FETCH, S_EXT0, S_EXT1, S_EXT2}) && !vld_p1 && !empty && !restart;
  assign pop        = pop_hdr || pop_dat;
  assign gate       = ce_tick && play && !motor_n;
  assign playing    = (state == S_PULSE) && play && !motor_n;
  assign wr.wr_ready = wr_ready_q;
  assign done_set   = last_seen && empty && !vld_p1 &&
                      (state inside {S_FETCH, S_EXT0, S_EXT1, S_EXT2});

  always_comb begin
    level_nxt = fifo_level;
    if (push && !pop)      level_nxt = fifo_level + 1'b1;
    else if (pop && !push) level_nxt = fifo_level - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    count_nxt = count;
    ext_nxt   = ext_acc;
    tape_nxt  = tape_out;
    unique case (state)
      S_HDR:
        if (pop_hdr && hdr_idx == HI_W'(HDR_LEN - 1)) state_nxt = S_FETCH;
      S_FETCH:
        if (vld_p1) begin
          if (rd_data_p1 != 8'd0) begin
            len_nxt   = tap_len({1'b0, rd_data_p1});
            count_nxt = len_nxt;
            state_nxt = S_PULSE;
          end else if (V1_EN != 0 && version != 8'd0) begin
            state_nxt = S_EXT0;
          end else begin
            len_nxt   = tap_len(9'd256);
            count_nxt = len_nxt;
            state_nxt = S_PULSE;
          end
        end
      S_EXT0, S_EXT1, S_EXT2:
        if (vld_p1) begin
          if (state == S_EXT0) begin
            ext_nxt[7:0] = rd_data_p1;
            state_nxt    = S_EXT1;
          end else if (state == S_EXT1) begin
            ext_nxt[15:8] = rd_data_p1;
            state_nxt     = S_EXT2;
          end else begin
            len_nxt   = ext_len({rd_data_p1, ext_acc});
            count_nxt = len_nxt;
            state_nxt = (len_nxt == '0) ? S_FETCH : S_PULSE;
          end
        end else if (empty && last_seen) begin
          // image ended inside a v1 triple: drop the partial length
          state_nxt = S_FETCH;
        end
      S_PULSE:
        if (gate) begin
          count_nxt = count - 1'b1;
          if (count == CNT_W'(1)) begin
            tape_nxt  = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            tape_nxt = (count <= (len >> 1));
          end
        end
      default: state_nxt = S_HDR;
    endcase
  end

  // stage p0 -> p1: FIFO storage, synchronous read and pulse datapath
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr.wr_data;
    if (pop)  rd_data_p1 <= mem[rd_ptr];
    len     <= len_nxt;
    count   <= count_nxt;
    ext_acc <= ext_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_HDR;
      hdr_idx    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      wr_ready_q <= 1'b0;
      vld_p1     <= 1'b0;
      ver_vld_p1 <= 1'b0;
      version    <= 8'd0;
      last_seen  <= 1'b0;
      done       <= 1'b0;
      tape_out   <= 1'b1;
    end else if (restart) begin
      state      <= S_HDR;
      hdr_idx    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      wr_ready_q <= 1'b0;
      vld_p1     <= 1'b0;
      ver_vld_p1 <= 1'b0;
      version    <= 8'd0;
      last_seen  <= 1'b0;
      done       <= 1'b0;
      tape_out   <= 1'b1;
    end else begin
      state      <= state_nxt;
      tape_out   <= tape_nxt;
      fifo_level <= level_nxt;
      wr_ready_q <= (level_nxt != (FIFO_AW + 1)'(DEPTH));
      vld_p1     <= pop_dat;
      ver_vld_p1 <= pop_hdr && (hdr_idx == HI_W'(VER_OFS));
      if (push)               wr_ptr  <= wr_ptr + 1'b1;
      if (pop)                rd_ptr  <= rd_ptr + 1'b1;
      if (pop_hdr)            hdr_idx <= hdr_idx + 1'b1;
      if (ver_vld_p1)         version <= rd_data_p1;
      if (push && wr.wr_last) last_seen <= 1'b1;
      if (done_set)           done    <= 1'b1;
    end
  end
endmodule
